// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: fetch FSM states and instruction constants.
package legv8_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DROP  = 2'd3
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;

   // Canonical LEGv8 NOP encoding; bubbles are marked with Valid_D=0 instead.
   localparam logic [31:0] LEGV8_NOP = 32'hD503201F;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears only the valid bit, load captures a
// new PC/instruction pair, otherwise the contents are held.
module if_id_reg
   import legv8_pkg::*;
#(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic               i_flush,
   input  logic [ADDR_W-1:0]  i_pc,
   input  logic [INSTR_W-1:0] i_instr,
   output logic [ADDR_W-1:0]  o_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic               o_valid
);

   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;

   // Flush has priority over load; neither asserted means hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_pc    <= i_pc;
         r_instr <= i_instr;
         r_valid <= 1'b1;
      end
   end

   assign o_pc    = r_pc;
   assign o_instr = r_instr;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch front end: owns the PC, talks to a variable-latency
// instruction memory over req/ready, buffers a response across load-use
// stalls and squashes wrong-path fetches on a MEM-stage redirect.
module fetch_unit
   import legv8_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned ADDR_W   = 64,
   parameter int unsigned INSTR_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PCWrite,
   input  logic               IF_ID_Write,
   input  logic               Branch_M,
   input  logic [ADDR_W-1:0]  BranchTarget_M,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0]  PC_D,
   output logic [INSTR_W-1:0] Instr_D,
   output logic               Valid_D,
   output logic [31:0]        StallCount
);

   fetch_state_t        r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [INSTR_W-1:0]  r_hold_buf;
   logic [ADDR_W-1:0]   r_drop_addr;
   logic [31:0]         r_stall_cnt;

   fetch_state_t        w_state_nxt;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic [INSTR_W-1:0]  w_hold_nxt;
   logic [ADDR_W-1:0]   w_drop_nxt;
   logic                w_ifid_load;
   logic                w_ifid_flush;
   logic [INSTR_W-1:0]  w_ifid_instr;
   logic                w_adv;
   logic [ADDR_W-1:0]   w_tgt;
   logic [ADDR_W-1:0]   w_pc_inc;
   logic                w_unused_tgt_lo;

   assign w_adv           = PCWrite && IF_ID_Write;
   assign w_tgt           = {BranchTarget_M[ADDR_W-1:2], 2'b00};
   assign w_pc_inc        = r_pc + ADDR_W'(INSTR_BYTES);
   assign w_unused_tgt_lo = ^BranchTarget_M[1:0];

   // Next-state, PC and IF/ID control decode; a redirect outranks any stall.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_hold_nxt   = r_hold_buf;
      w_drop_nxt   = r_drop_addr;
      w_ifid_load  = 1'b0;
      w_ifid_flush = 1'b0;
      w_ifid_instr = imem_rdata;
      unique case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (Branch_M) begin
               w_pc_nxt     = w_tgt;
               w_ifid_flush = 1'b1;
               // An unfinished request must still be drained, so remember its
               // address to keep imem_addr stable while it completes.
               if (!imem_ready) begin
                  w_drop_nxt  = r_pc;
                  w_state_nxt = ST_DROP;
               end
            end else if (imem_ready) begin
               if (w_adv) begin
                  w_ifid_load  = 1'b1;
                  w_ifid_instr = imem_rdata;
                  w_pc_nxt     = w_pc_inc;
               end else begin
                  w_hold_nxt  = imem_rdata;
                  w_state_nxt = ST_HOLD;
               end
            end else if (IF_ID_Write) begin
               w_ifid_flush = 1'b1;
            end
         end
         ST_HOLD: begin
            if (Branch_M) begin
               w_pc_nxt     = w_tgt;
               w_ifid_flush = 1'b1;
               w_state_nxt  = ST_FETCH;
            end else if (w_adv) begin
               w_ifid_load  = 1'b1;
               w_ifid_instr = r_hold_buf;
               w_pc_nxt     = w_pc_inc;
               w_state_nxt  = ST_FETCH;
            end
         end
         ST_DROP: begin
            w_ifid_flush = IF_ID_Write || Branch_M;
            if (Branch_M) begin
               w_pc_nxt = w_tgt;
            end else if (imem_ready) begin
               w_state_nxt = ST_FETCH;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM, PC and the stall-time response/drop bookkeeping registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_pc        <= RESET_PC[ADDR_W-1:0];
         r_hold_buf  <= '0;
         r_drop_addr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_hold_buf  <= w_hold_nxt;
         r_drop_addr <= w_drop_nxt;
      end
   end

   // Saturating count of active cycles with the PC frozen by the hazard unit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if ((r_state != ST_IDLE) && !PCWrite && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_if_id (
      .clk     (clk),
      .rst_n   (reset),
      .i_load  (w_ifid_load),
      .i_flush (w_ifid_flush),
      .i_pc    (r_pc),
      .i_instr (w_ifid_instr),
      .o_pc    (PC_D),
      .o_instr (Instr_D),
      .o_valid (Valid_D)
   );

   assign imem_req   = (r_state == ST_FETCH) || (r_state == ST_DROP);
   assign imem_addr  = (r_state == ST_DROP) ? r_drop_addr : r_pc;
   assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run compared cycle-by-cycle against a behavioural fetch-stream model.
module tb_fetch_unit;

   localparam logic [63:0] RST_PC = 64'h1000;

   logic        clk;
   logic        rst_n;
   logic        pcw, ifw, br, rdy;
   logic [63:0] tgt;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [63:0] PC_D;
   logic [31:0] Instr_D;
   logic        Valid_D;
   logic [31:0] StallCount;

   int total = 0;
   int bad   = 0;

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
   endfunction

   assign imem_rdata = instr_of(imem_addr);

   fetch_unit #(
      .RESET_PC (RST_PC),
      .ADDR_W   (64),
      .INSTR_W  (32)
   ) dut (
      .clk            (clk),
      .reset          (rst_n),
      .PCWrite        (pcw),
      .IF_ID_Write    (ifw),
      .Branch_M       (br),
      .BranchTarget_M (tgt),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (rdy),
      .imem_rdata     (imem_rdata),
      .PC_D           (PC_D),
      .Instr_D        (Instr_D),
      .Valid_D        (Valid_D),
      .StallCount     (StallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: next PC to fetch, whether the stream has started,
   // whether a fetched word is parked, whether the outstanding request is
   // wrong-path, and the expected decode-stage contents.
   bit          m_started, m_parked, m_discard;
   logic [63:0] m_pc, m_stale, m_dpc;
   logic [31:0] m_dins, m_cnt;
   bit          m_dv;

   task automatic model_reset();
      m_started = 0; m_parked = 0; m_discard = 0;
      m_pc = RST_PC; m_stale = '0; m_dpc = '0; m_dins = '0; m_dv = 0; m_cnt = '0;
   endtask

   task automatic model_step();
      bit          was_active;
      bit          adv;
      logic [63:0] t4;
      was_active = m_started;
      adv = pcw && ifw;
      t4  = {tgt[63:2], 2'b00};
      if (!m_started) begin
         m_started = 1;
      end else if (m_discard) begin
         if (br) m_pc = t4;
         else if (rdy) m_discard = 0;
         if (ifw || br) m_dv = 0;
      end else if (m_parked) begin
         if (br) begin
            m_parked = 0; m_pc = t4; m_dv = 0;
         end else if (adv) begin
            m_dpc = m_pc; m_dins = instr_of(m_pc); m_dv = 1;
            m_pc = m_pc + 64'd4; m_parked = 0;
         end
      end else begin
         if (br) begin
            m_dv = 0;
            if (!rdy) begin m_stale = m_pc; m_discard = 1; end
            m_pc = t4;
         end else if (rdy) begin
            if (adv) begin
               m_dpc = m_pc; m_dins = instr_of(m_pc); m_dv = 1; m_pc = m_pc + 64'd4;
            end else begin
               m_parked = 1;
            end
         end else if (ifw) begin
            m_dv = 0;
         end
      end
      if (was_active && !pcw && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
   endtask

   // One clock: drive inputs, update the model at the edge, settle for sampling.
   task automatic step(input bit p, input bit i, input bit b, input logic [63:0] t, input bit r);
      pcw = p; ifw = i; br = b; tgt = t; rdy = r;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; pcw = 1; ifw = 1; br = 0; tgt = '0; rdy = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; pcw = 1; ifw = 1; br = 0; tgt = '0; rdy = 0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if ({imem_req, imem_addr, PC_D, Instr_D, Valid_D, StallCount} !==
          {1'b0, RST_PC, 64'h0, 32'h0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL reset_values: req=%b addr=%h pcd=%h ins=%h v=%b sc=%0d expected req=0 addr=%h rest zero",
                  imem_req, imem_addr, PC_D, Instr_D, Valid_D, StallCount, RST_PC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 1, 0, '0, 0);
      total++;
      if ({imem_req, imem_addr, Valid_D} !== {1'b1, RST_PC, 1'b0}) begin
         bad++;
         $display("FAIL first_request: req=%b addr=%h v=%b expected 1 %h 0", imem_req, imem_addr, Valid_D, RST_PC);
      end
   endtask

   task automatic test_zero_wait();
      logic [63:0] e;
      apply_reset();
      step(1, 1, 0, '0, 1);
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 0, '0, 1);
         e = RST_PC + 64'(4 * k);
         total++;
         if ({PC_D, Instr_D, Valid_D} !== {e, instr_of(e), 1'b1}) begin
            bad++;
            $display("FAIL zero_wait[%0d]: pcd=%h ins=%h v=%b expected %h %h 1", k, PC_D, Instr_D, Valid_D, e, instr_of(e));
         end
      end
   endtask

   task automatic test_latency();
      apply_reset();
      step(1, 1, 0, '0, 1);
      step(1, 1, 0, '0, 1);
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({imem_req, imem_addr} !== {1'b1, RST_PC + 64'd4}) begin
            bad++;
            $display("FAIL latency_addr[%0d]: req=%b addr=%h expected 1 %h", k, imem_req, imem_addr, RST_PC + 64'd4);
         end
         step(1, 1, 0, '0, (k == 2));
         if (k < 2) begin
            total++;
            if (Valid_D !== 1'b0) begin
               bad++;
               $display("FAIL latency_bubble[%0d]: v=%b expected 0", k, Valid_D);
            end
         end
      end
      total++;
      if ({PC_D, Valid_D} !== {RST_PC + 64'd4, 1'b1}) begin
         bad++;
         $display("FAIL latency_deliver: pcd=%h v=%b expected %h 1", PC_D, Valid_D, RST_PC + 64'd4);
      end
   endtask

   task automatic test_hold();
      apply_reset();
      step(1, 1, 0, '0, 1);
      step(1, 1, 0, '0, 1);
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 0, '0, 1);
         total++;
         if ({imem_req, PC_D, Instr_D, Valid_D} !== {1'b0, RST_PC, instr_of(RST_PC), 1'b1}) begin
            bad++;
            $display("FAIL hold_stall[%0d]: req=%b pcd=%h ins=%h v=%b expected 0 %h %h 1",
                     k, imem_req, PC_D, Instr_D, Valid_D, RST_PC, instr_of(RST_PC));
         end
      end
      total++;
      if (StallCount !== 32'd2) begin
         bad++;
         $display("FAIL hold_count: sc=%0d expected 2", StallCount);
      end
      step(1, 1, 0, '0, 0);
      total++;
      if ({PC_D, Instr_D, Valid_D, imem_req, imem_addr, StallCount} !==
          {RST_PC + 64'd4, instr_of(RST_PC + 64'd4), 1'b1, 1'b1, RST_PC + 64'd8, 32'd2}) begin
         bad++;
         $display("FAIL hold_release: pcd=%h ins=%h v=%b req=%b addr=%h sc=%0d expected %h %h 1 1 %h 2",
                  PC_D, Instr_D, Valid_D, imem_req, imem_addr, StallCount,
                  RST_PC + 64'd4, instr_of(RST_PC + 64'd4), RST_PC + 64'd8);
      end
   endtask

   task automatic test_branch_drop();
      apply_reset();
      step(1, 1, 0, '0, 1);
      step(1, 1, 0, '0, 1);
      step(1, 1, 1, 64'h2003, 0);
      total++;
      if ({Valid_D, imem_req, imem_addr} !== {1'b0, 1'b1, RST_PC + 64'd4}) begin
         bad++;
         $display("FAIL drop_enter: v=%b req=%b addr=%h expected 0 1 %h", Valid_D, imem_req, imem_addr, RST_PC + 64'd4);
      end
      step(1, 1, 0, '0, 0);
      step(1, 1, 0, '0, 1);
      total++;
      if ({Valid_D, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h2000}) begin
         bad++;
         $display("FAIL drop_exit: v=%b req=%b addr=%h expected 0 1 2000", Valid_D, imem_req, imem_addr);
      end
      step(1, 1, 0, '0, 1);
      total++;
      if ({PC_D, Instr_D, Valid_D} !== {64'h2000, instr_of(64'h2000), 1'b1}) begin
         bad++;
         $display("FAIL drop_target: pcd=%h ins=%h v=%b expected 2000 %h 1", PC_D, Instr_D, Valid_D, instr_of(64'h2000));
      end
   endtask

   task automatic test_branch_hold();
      apply_reset();
      step(1, 1, 0, '0, 1);
      step(1, 1, 0, '0, 1);
      step(0, 0, 0, '0, 1);
      step(0, 0, 1, 64'h3000, 0);
      total++;
      if ({Valid_D, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h3000}) begin
         bad++;
         $display("FAIL hold_branch: v=%b req=%b addr=%h expected 0 1 3000", Valid_D, imem_req, imem_addr);
      end
      step(1, 1, 0, '0, 1);
      total++;
      if ({PC_D, Instr_D, Valid_D} !== {64'h3000, instr_of(64'h3000), 1'b1}) begin
         bad++;
         $display("FAIL hold_branch_target: pcd=%h ins=%h v=%b expected 3000 %h 1", PC_D, Instr_D, Valid_D, instr_of(64'h3000));
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      step(1, 1, 0, '0, 1);
      step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
      total++;
      if ({Valid_D, imem_req, imem_addr} !== {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
         bad++;
         $display("FAIL wrap_redirect: v=%b req=%b addr=%h expected 0 1 fffffffffffffffc", Valid_D, imem_req, imem_addr);
      end
      step(1, 1, 0, '0, 1);
      total++;
      if ({PC_D, Valid_D, imem_addr} !== {64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h0}) begin
         bad++;
         $display("FAIL wrap_next: pcd=%h v=%b addr=%h expected fffffffffffffffc 1 0", PC_D, Valid_D, imem_addr);
      end
      step(1, 1, 0, '0, 1);
      total++;
      if ({PC_D, Instr_D} !== {64'h0, instr_of(64'h0)}) begin
         bad++;
         $display("FAIL wrap_zero: pcd=%h ins=%h expected 0 %h", PC_D, Instr_D, instr_of(64'h0));
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      step(1, 1, 0, '0, 1);
      step(1, 1, 0, '0, 1);
      step(0, 0, 0, '0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if ({imem_req, imem_addr, PC_D, Instr_D, Valid_D, StallCount} !==
          {1'b0, RST_PC, 64'h0, 32'h0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL async_reset: req=%b addr=%h pcd=%h ins=%h v=%b sc=%0d expected 0 %h 0 0 0 0",
                  imem_req, imem_addr, PC_D, Instr_D, Valid_D, StallCount, RST_PC);
      end
   endtask

   task automatic test_random();
      logic [193:0] act, exp;
      logic [63:0]  t;
      bit p, i, b, r;
      apply_reset();
      for (int n = 0; n < 600; n++) begin
         p = ($urandom_range(0, 3) != 0);
         i = ($urandom_range(0, 3) != 0);
         b = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 1) == 1);
         t = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, t[3:0]};
         step(p, i, b, t, r);
         act = {imem_req, imem_addr, PC_D, Instr_D, Valid_D, StallCount};
         exp = {m_started && !m_parked, (m_discard ? m_stale : m_pc), m_dpc, m_dins, m_dv, m_cnt};
         total++;
         if (act !== exp) begin
            bad++;
            $display("FAIL random[%0d]: got %h want %h", n, act, exp);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; pcw = 1; ifw = 1; br = 0; tgt = '0; rdy = 0;
      model_reset();
      test_reset();
      test_zero_wait();
      test_latency();
      test_hold();
      test_branch_drop();
      test_branch_hold();
      test_wrap();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
